// File: rtl/countdown_timer_if.sv
// Load handshake bundle for countdown_timer.
// The producer (master) offers a start value with load_valid; the timer
// (slave) reports through load_ready whether it can take one this cycle.
interface countdown_timer_if #(
    parameter int WIDTH = 3
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle done state.
// A start value arrives over the load handshake in countdown_timer_if.
// The value is clamped to MAX_COUNT and counted down on enabled cycles.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When it is defined, the
// last accepted load value is kept and the countdown restarts automatically
// from DONE.
module countdown_timer #(
    parameter int MAX_COUNT   = 6,
    parameter int COUNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    countdown_timer_if.slave        load_if,
    input  logic                    enable,
    input  logic                    abort,
    output logic [COUNT_WIDTH-1:0]  count,
    output logic                    busy,
    output logic                    done,
    output logic                    load_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

    state_t                 state;
    state_t                 next_state;
    logic [COUNT_WIDTH-1:0] next_count;
    logic                   next_err;
    logic                   load_fire;
    logic                   load_over;
    logic [COUNT_WIDTH-1:0] load_clamped;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [COUNT_WIDTH-1:0] reload;
`endif

    // Handshake status and observable flags are decoded only from the state register
    always_comb begin
        load_if.load_ready = (state != RUN);
        busy               = (state == RUN);
        done               = (state == DONE);
    end

    // Qualify the load request and clamp the offered value into range
    always_comb begin
        load_fire    = load_if.load_valid && (state != RUN);
        load_over    = (load_if.load_value > MAX_VAL);
        load_clamped = load_over ? MAX_VAL : load_if.load_value;
    end

    // Next-state and next-count decision; a taken load outranks everything else outside RUN
    always_comb begin
        next_state = state;
        next_count = count;
        next_err   = 1'b0;
        case (state)
            IDLE: begin
                if (load_fire) begin
                    next_count = load_clamped;
                    next_state = (load_clamped != '0) ? RUN : DONE;
                    next_err   = load_over;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                    next_count = '0;
                end else if (enable) begin
                    if (count > ONE) begin
                        next_count = count - ONE;
                    end else begin
                        next_count = '0;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (load_fire) begin
                    next_count = load_clamped;
                    next_state = (load_clamped != '0) ? RUN : DONE;
                    next_err   = load_over;
                end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (abort) begin
                        next_state = IDLE;
                        next_count = '0;
                    end else if (reload != '0) begin
                        next_count = reload;
                        next_state = RUN;
                    end else begin
                        next_state = DONE;
                    end
`else
                    next_state = IDLE;
`endif
                end
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
            end
        endcase
    end

    // State, count and error-pulse registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            load_err <= next_err;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Remember the clamped value of every accepted load for automatic restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
        end else if (load_fire) begin
            reload <= load_clamped;
        end
    end
`endif

endmodule
